// File: rtl/circuit_probe_sequencer.sv
// Truth-table characterisation sequencer: sweeps every input vector of a small
// combinational circuit, samples its output and grades it against an expected table.
module circuit_probe_sequencer #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 q,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_err,
  output logic                 err_valid,
  output logic                 pass
);

  localparam int TW = 2**N_IN;
  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);
  localparam logic [3:0]      CNT_ONE   = 4'd1;
  localparam logic [N_IN-1:0] IDX_ONE   = N_IN'(1);
  localparam logic [N_IN-1:0] IDX_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN:0]   MC_ZERO   = {(N_IN+1){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_r;
  logic [3:0]      cnt_r;
  logic [N_IN-1:0] idx_r;
  logic [TW-1:0]   exp_r;
  logic [N_IN-1:0] vec_r;
  logic            busy_r;
  logic            done_r;
  logic [TW-1:0]   table_r;
  logic [N_IN:0]   mismatch_cnt_r;
  logic [N_IN-1:0] first_err_r;
  logic            err_valid_r;
  logic            pass_r;

  logic            miss_s;
  logic [N_IN:0]   mismatch_next_s;

  // Grade the vector currently being sampled.
  always_comb begin
    miss_s          = (q != exp_r[idx_r]);
    mismatch_next_s = mismatch_cnt_r + {{N_IN{1'b0}}, miss_s};
  end

  // Sweep state machine; every output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 4'd0;
      idx_r          <= {N_IN{1'b0}};
      exp_r          <= {TW{1'b0}};
      vec_r          <= {N_IN{1'b0}};
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      table_r        <= {TW{1'b0}};
      mismatch_cnt_r <= MC_ZERO;
      first_err_r    <= {N_IN{1'b0}};
      err_valid_r    <= 1'b0;
      pass_r         <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && abort) begin
            pass_r <= 1'b0;
          end else if (start) begin
            exp_r          <= expected;
            table_r        <= {TW{1'b0}};
            mismatch_cnt_r <= MC_ZERO;
            first_err_r    <= {N_IN{1'b0}};
            err_valid_r    <= 1'b0;
            pass_r         <= 1'b0;
            idx_r          <= {N_IN{1'b0}};
            vec_r          <= {N_IN{1'b0}};
            cnt_r          <= SETTLE_LD;
            busy_r         <= 1'b1;
            state_r        <= ST_SETTLE;
          end else begin
            vec_r <= {N_IN{1'b0}};
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            vec_r   <= {N_IN{1'b0}};
            pass_r  <= 1'b0;
          end else if (cnt_r == CNT_ONE) begin
            state_r <= ST_SAMPLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            vec_r   <= {N_IN{1'b0}};
            pass_r  <= 1'b0;
          end else begin
            table_r[idx_r] <= q;
            mismatch_cnt_r <= mismatch_next_s;
            if (miss_s && !err_valid_r) begin
              first_err_r <= idx_r;
              err_valid_r <= 1'b1;
            end
            // The last vector ends the sweep; idx never wraps back to 0.
            if (idx_r == IDX_LAST) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              pass_r  <= (mismatch_next_s == MC_ZERO);
              busy_r  <= 1'b0;
              vec_r   <= {N_IN{1'b0}};
            end else begin
              idx_r   <= idx_r + IDX_ONE;
              vec_r   <= idx_r + IDX_ONE;
              cnt_r   <= SETTLE_LD;
              state_r <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign vec          = vec_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign table_out    = table_r;
  assign mismatch_cnt = mismatch_cnt_r;
  assign first_err    = first_err_r;
  assign err_valid    = err_valid_r;
  assign pass         = pass_r;

endmodule

// File: tb/tb_circuit_probe_sequencer.sv
// Bench for circuit_probe_sequencer: two instances (SETTLE=1 and SETTLE=3) share
// control inputs; results are graded against a truth-table model.
module tb_circuit_probe_sequencer;

  localparam int TW = 16;
  localparam int NONE = 1000;

  logic clk = 1'b0;
  logic reset, start, abort;
  logic [15:0] expected;
  logic q1, q3, nz1, nz3;
  logic [15:0] circ_tt;
  logic [3:0] vec1, vec3, fe1, fe3;
  logic busy1, busy3, done1, done3, ev1, ev3, pass1, pass3;
  logic [15:0] tab1, tab3;
  logic [4:0] mc1, mc3;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Device under test: output follows the circuit table, with noise on non-sample cycles.
  assign q1 = circ_tt[vec1] ^ nz1;
  assign q3 = circ_tt[vec3] ^ nz3;

  circuit_probe_sequencer #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .expected(expected), .q(q1),
    .vec(vec1), .busy(busy1), .done(done1), .table_out(tab1), .mismatch_cnt(mc1),
    .first_err(fe1), .err_valid(ev1), .pass(pass1));

  circuit_probe_sequencer #(.N_IN(4), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .expected(expected), .q(q3),
    .vec(vec3), .busy(busy3), .done(done3), .table_out(tab3), .mismatch_cnt(mc3),
    .first_err(fe3), .err_valid(ev3), .pass(pass3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; noise is only allowed where the next edge is not a sample edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    nz1 = (((cyc + 1) % 2) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    nz3 = (((cyc + 1) % 4) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic model(input int n, input logic [15:0] tt, input logic [15:0] ex,
                       output logic [15:0] tab, output int cnt, output int first, output bit ev);
    tab = 16'h0000; cnt = 0; first = 0; ev = 1'b0;
    for (int k = 0; k < n; k++) begin
      tab[k] = tt[k];
      if (tt[k] != ex[k]) begin
        cnt++;
        if (!ev) begin first = k; ev = 1'b1; end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vec1"}, 32'(vec1), 32'd0);
    check({tag, "_busy1"}, 32'(busy1), 32'd0);
    check({tag, "_done1"}, 32'(done1), 32'd0);
    check({tag, "_tab1"}, 32'(tab1), 32'd0);
    check({tag, "_mc1"}, 32'(mc1), 32'd0);
    check({tag, "_fe1"}, 32'(fe1), 32'd0);
    check({tag, "_ev1"}, 32'(ev1), 32'd0);
    check({tag, "_pass1"}, 32'(pass1), 32'd0);
    check({tag, "_busy3"}, 32'(busy3), 32'd0);
    check({tag, "_tab3"}, 32'(tab3), 32'd0);
    check({tag, "_mc3"}, 32'(mc3), 32'd0);
    check({tag, "_pass3"}, 32'(pass3), 32'd0);
  endtask

  // One sweep on both instances, optionally cut short by abort or reset at a given cycle.
  task automatic sweep(input string tag, input logic [15:0] ex, input int abort_at,
                       input int reset_at, input bit pokes);
    int lim, n1, n3, d1, d3, t1, t3, c1, c3, f1, f3;
    bit e1, e3, complete;
    logic [15:0] m1, m3;
    lim = (abort_at < reset_at) ? abort_at : reset_at;
    complete = (lim == NONE);
    expected = ex; start = 1'b1; abort = 1'b0; reset = 1'b0;
    cyc = -1;
    tick();
    start = 1'b0;
    expected = 16'($urandom);
    d1 = 0; d3 = 0; t1 = -1; t3 = -1;
    repeat (70) begin
      start = pokes && (cyc == 5 || cyc == 20);
      abort = (cyc == abort_at);
      reset = (cyc == reset_at);
      tick();
      if (done1) begin d1++; if (t1 < 0) t1 = cyc; check({tag, "_busy1_at_done"}, 32'(busy1), 32'd0); end
      if (done3) begin d3++; if (t3 < 0) t3 = cyc; check({tag, "_busy3_at_done"}, 32'(busy3), 32'd0); end
      if (cyc <= lim && cyc < TW * 2) begin
        check({tag, "_vec1"}, 32'(vec1), 32'(cyc / 2));
        check({tag, "_busy1"}, 32'(busy1), 32'd1);
      end
      if (cyc <= lim && cyc < TW * 4) begin
        check({tag, "_vec3"}, 32'(vec3), 32'(cyc / 4));
        check({tag, "_busy3"}, 32'(busy3), 32'd1);
      end
      if (cyc == abort_at + 1) begin
        check({tag, "_abort_busy1"}, 32'(busy1), 32'd0);
        check({tag, "_abort_vec1"}, 32'(vec1), 32'd0);
        check({tag, "_abort_busy3"}, 32'(busy3), 32'd0);
        check({tag, "_abort_vec3"}, 32'(vec3), 32'd0);
      end
      if (cyc == reset_at + 1) check_zero({tag, "_reset"});
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    if (reset_at != NONE) begin n1 = 0; n3 = 0; end
    else if (abort_at != NONE) begin n1 = abort_at / 2; n3 = abort_at / 4; end
    else begin n1 = TW; n3 = TW; end
    model(n1, circ_tt, ex, m1, c1, f1, e1);
    model(n3, circ_tt, ex, m3, c3, f3, e3);
    check({tag, "_tab1"}, 32'(tab1), 32'(m1));
    check({tag, "_mc1"}, 32'(mc1), 32'(c1));
    check({tag, "_fe1"}, 32'(fe1), 32'(f1));
    check({tag, "_ev1"}, 32'(ev1), 32'(e1));
    check({tag, "_pass1"}, 32'(pass1), 32'(complete && c1 == 0));
    check({tag, "_tab3"}, 32'(tab3), 32'(m3));
    check({tag, "_mc3"}, 32'(mc3), 32'(c3));
    check({tag, "_fe3"}, 32'(fe3), 32'(f3));
    check({tag, "_ev3"}, 32'(ev3), 32'(e3));
    check({tag, "_pass3"}, 32'(pass3), 32'(complete && c3 == 0));
    check({tag, "_ndone1"}, 32'(d1), 32'(complete ? 1 : 0));
    check({tag, "_ndone3"}, 32'(d3), 32'(complete ? 1 : 0));
    if (complete) begin
      check({tag, "_tdone1"}, 32'(t1), 32'(TW * 2));
      check({tag, "_tdone3"}, 32'(t3), 32'(TW * 4));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; expected = 16'h0000;
    nz1 = 1'b0; nz3 = 1'b0;
    for (int v = 0; v < TW; v++) circ_tt[v] = v[2] | v[1];
    tick(); tick();
    reset = 1'b0;
    tick();
    check_zero("por");

    sweep("bc_exact", 16'hFCFC, NONE, NONE, 1'b0);
    check("bc_exact_tab_const", 32'(tab1), 32'h0000FCFC);
    sweep("bc_zero", 16'h0000, NONE, NONE, 1'b0);
    check("bc_zero_cnt_const", 32'(mc1), 32'd12);
    check("bc_zero_first_const", 32'(fe1), 32'd2);
    sweep("bc_onebit", 16'hFCFD, NONE, NONE, 1'b0);
    check("bc_onebit_cnt_const", 32'(mc1), 32'd1);
    sweep("pokes", 16'hFCFC, NONE, NONE, 1'b1);
    sweep("abort", 16'h0F0F, 10, NONE, 1'b0);
    sweep("after_abort", 16'hFCFC, NONE, NONE, 1'b0);

    // start and abort together while idle: no sweep, pass drops, table stays.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy1", 32'(busy1), 32'd0);
    tick();
    check("sa_busy1_b", 32'(busy1), 32'd0);
    check("sa_busy3", 32'(busy3), 32'd0);
    check("sa_done1", 32'(done1), 32'd0);
    check("sa_pass1", 32'(pass1), 32'd0);
    check("sa_tab1", 32'(tab1), 32'(circ_tt));

    sweep("reset_mid", 16'hFCFC, NONE, 15, 1'b0);
    sweep("after_reset", 16'hFCFC, NONE, NONE, 1'b0);

    for (int r = 0; r < 6; r++) begin
      circ_tt = 16'($urandom);
      if (r % 3 == 0) sweep("rand_exact", circ_tt, NONE, NONE, 1'b0);
      else sweep("rand_diff", circ_tt ^ 16'($urandom & $urandom), NONE, NONE, 1'b0);
    end
    sweep("rand_all_wrong", ~circ_tt, NONE, NONE, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/circuit_probe_sequencer.md
Name: circuit_probe_sequencer

Overview:
Characterisation sequencer for the small 4-input combinational circuits in the circuit family (e.g. q = b | c).
- On a start pulse it drives every input vector in ascending order and holds each one for a settle window.
- It samples the circuit's single output and assembles the measured truth table.
- It compares the table bit-by-bit against an expected table and reports pass/fail, mismatch count and first failing vector.
- Sits between a test/control host and one circuit instance; owns the circuit's inputs while busy.

Parameters:
N_IN, 4, number of circuit inputs; vector width; table width TW = 2**N_IN
SETTLE, 1, cycles each vector is held before its sample cycle; legal range 1..15

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
start  input  1  begin a sweep; honoured only in IDLE
abort  input  1  cancel sweep; has priority over start
expected  input  TW  expected truth table, bit i = expected q for vector i; latched on accepted start
q  input  1  circuit output under test
vec  output  N_IN  circuit input vector {a,b,c,d}, a = MSB
busy  output  1  sweep in progress
done  output  1  one-cycle pulse, sweep completed normally
table_out  output  TW  measured truth table, bit i = sampled q for vector i
mismatch_cnt  output  N_IN+1  count of bits where measured != expected
first_err  output  N_IN  index of lowest mismatching vector
err_valid  output  1  first_err holds a valid index
pass  output  1  last completed sweep had zero mismatches

Behaviour:
- Reset applies when reset=1 at the clock edge. It forces state IDLE and sets every output to 0 (vec, busy, done, table_out, mismatch_cnt, first_err, err_valid, pass). The settle counter, index and latched expected also clear.
- Reset mid-sweep discards all partial results.
- States:
  - IDLE: vec = 0; results hold their last values.
  - SETTLE: hold vec for SETTLE cycles, counter counting down.
  - SAMPLE: one cycle; at its closing edge:
    - table_out[idx] <= q
    - if q != exp_q[idx], mismatch_cnt increments; on the first mismatch of the sweep, first_err <= idx and err_valid <= 1
    - if idx == TW-1, go to DONE; else vec/idx increment and go to SETTLE
  - DONE: done = 1 and pass = (mismatch_cnt == 0), both set at the edge entering DONE. The next edge returns to IDLE; done drops, pass holds.
- Accepted start (IDLE, start=1, abort=0) at edge E0:
  - latch expected into exp_q
  - clear table_out, mismatch_cnt, first_err, err_valid, pass
  - set vec = 0, busy = 1, enter SETTLE
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - Vector k is sampled at edge E0 + (k+1)*(SETTLE+1).
  - busy falls and done rises at edge E0 + TW*(SETTLE+1). For N_IN=4, SETTLE=1 that is E0+32.
- start while busy: ignored; no restart, no effect on results.
- abort while busy, or abort in the same cycle as start: next edge goes to IDLE with busy=0, vec=0, no done pulse, pass=0. Partial table_out, mismatch_cnt, first_err and err_valid remain visible.
- Arithmetic:
  - vec/idx are N_IN bits; the sweep ends on idx == TW-1 and never wraps.
  - mismatch_cnt is N_IN+1 bits, so TW mismatches fit (16 -> 5'd16).
- done and pass are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Circuit q=b|c, expected=16'hFCFC, SETTLE=1, start at E0 -> table_out=16'hFCFC, mismatch_cnt=0, err_valid=0, done pulse at E0+32, pass=1.
- Same circuit, expected=16'h0000 -> mismatch_cnt=12, first_err=2, err_valid=1, pass=0; expected=16'hFCFD -> mismatch_cnt=1, first_err=0.
- SETTLE=3 -> vec changes every 4 cycles (0,1,...,15); done at E0+64; q sampled only on 4th cycle of each vector (toggle q on settle cycles, verify no effect).
- abort asserted at E0+10 -> busy=0 at E0+11, vec=0, no done; table_out bits 0..4 populated; then new start -> full sweep passes, abort-run data cleared.
- start pulsed again at E0+5 and E0+20 during sweep -> ignored, done still at E0+32 with correct results; start+abort together in IDLE -> no sweep.
- reset asserted at E0+15 -> next edge all outputs 0, state IDLE; subsequent start completes normally with pass=1.
